decode_stage: RTL
=================

Name: decode_stage

Overview:
Y86-64 pipeline D stage, directly downstream of the combinational fetch stage. Contains:
- the D pipeline register, which latches fetch outputs with stall/bubble control;
- the 15-entry x 64-bit program register file, written from W stage;
- srcA/srcB/dstE/dstM selection;
- the valA/valB forwarding network.
Outputs feed the E pipeline register and the hazard-control unit.

Parameters:
DATA_W, 64, register and operand width
NUM_REGS, 15, architectural registers (IDs 0x0..0xE; 0xF = NREG)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  synchronous active-low reset
D_stall_i  in  1  hold D register
D_bubble_i  in  1  load NOP bubble into D register
f_icode_i  in  4  from fetch
f_ifun_i  in  4  from fetch
f_rA_i  in  4  from fetch
f_rB_i  in  4  from fetch
f_valC_i  in  64  from fetch
f_valP_i  in  64  from fetch
f_stat_i  in  STAT_BUS  from fetch
e_dstE_i  in  4  execute destination
e_valE_i  in  64  execute result
M_dstM_i  in  4  memory-stage load destination
m_valM_i  in  64  memory read data
M_dstE_i  in  4  memory-stage E destination
M_valE_i  in  64  memory-stage E value
W_dstM_i  in  4  writeback load destination
W_valM_i  in  64  writeback load value
W_dstE_i  in  4  writeback E destination
W_valE_i  in  64  writeback E value
d_stat_o  out  STAT_BUS  D register stat
d_icode_o  out  4  D register icode
d_ifun_o  out  4  D register ifun
d_valC_o  out  64  D register valC
d_valA_o  out  64  selected/forwarded A operand
d_valB_o  out  64  forwarded B operand
d_dstE_o  out  4  E destination
d_dstM_o  out  4  M destination
d_srcA_o  out  4  A source, for hazard unit
d_srcB_o  out  4  B source, for hazard unit

Behaviour:
- D register, updated on rising edge of clk_i. Priority order:
  - rst_n_i=0 → bubble value.
  - else D_stall_i=1 → hold. Stall wins over bubble when both are asserted.
  - else D_bubble_i=1 → bubble value.
  - else load f_* inputs.
- Bubble value: icode=INOP, ifun=0, rA=rB=NREG, valC=valP=0, stat=SAOK.
- Register file:
  - Reset: all 15 registers cleared to 0 (synchronous).
  - Write on rising edge: W_dstE_i←W_valE_i and W_dstM_i←W_valM_i. Writes to NREG are ignored.
  - If W_dstE_i==W_dstM_i (not NREG), W_valM_i is written (dstM priority, required for popq %rsp).
  - Reads are combinational. Same-cycle writes are covered by forwarding, not by write-through.
- srcA:
  - rrmovq/cmovXX, rmmovq, OPq, pushq → rA
  - popq, ret → RSP(0x4)
  - else NREG
- srcB:
  - OPq, rmmovq, mrmovq → rB
  - pushq, popq, call, ret → RSP
  - else NREG
- dstE:
  - rrmovq/cmovXX, irmovq, OPq → rB (condition squash happens in execute)
  - pushq, popq, call, ret → RSP
  - else NREG
- dstM: mrmovq, popq → rA; else NREG.
- d_valA_o: call or jXX → D valP. Otherwise first match wins:
  1. srcA==e_dstE → e_valE
  2. ==M_dstM → m_valM
  3. ==M_dstE → M_valE
  4. ==W_dstM → W_valM
  5. ==W_dstE → W_valE
  6. else regfile[srcA]
- d_valB_o: same forwarding chain on srcB, with no valP case.
- A NREG source never matches and yields 0. Invalid icodes yield NREG for all src/dst.
- All d_* outputs are combinational from the D register plus the forwarding inputs (zero latency).
- Reset mid-operation: the next edge forces the bubble and clears registers regardless of stall/bubble.

Decomposition:
- Shared package/define file: icode constants (IHALT..IPOPQ, INOP), RSP, NREG, stat codes, DATA_BUS/STAT_BUS widths.
- One sub-module: regfile (15x64, two combinational read ports, two sync write ports, dstM priority, sync active-low clear).

Test Plan:
- Reset: hold rst_n_i=0 for 2 cycles → d_icode_o=INOP, d_stat_o=SAOK, d_srcA_o/d_dstE_o=NREG; irmovq read of any register via W-free path returns 0.
- Writeback then read: W_dstE=0x3, W_valE=0x1234 for one edge, then D=rrmovq rA=3 with no forwards → d_valA_o=0x1234, d_dstE_o=rB.
- Forward priority: srcA=2, e_dstE=2/e_valE=0xA, M_dstE=2/M_valE=0xB, W_dstE=2/W_valE=0xC → d_valA_o=0xA; drop e_dstE to NREG → 0xB.
- Call valP: D=call with valP=0x40 while e_dstE=RSP → d_valA_o=0x40, d_valB_o=e_valE, d_dstE_o=RSP.
- Stall/bubble: load OPq, then assert stall+bubble together → D unchanged; bubble alone → icode=INOP.
- Write collision: W_dstE=W_dstM=RSP, valE=0x100, valM=0x200 → next read of RSP=0x200.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - Y86-64 decode stage constants, D register layout and bubble value
package decode_stage_pkg;

    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 15;
    localparam int STAT_W   = 3;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RSP  = 4'h4;
    localparam logic [3:0] NREG = 4'hF;

    localparam logic [STAT_W-1:0] SAOK = 3'd1;
    localparam logic [STAT_W-1:0] SADR = 3'd2;
    localparam logic [STAT_W-1:0] SINS = 3'd3;
    localparam logic [STAT_W-1:0] SHLT = 3'd4;

    typedef struct packed {
        logic [STAT_W-1:0] stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [3:0]        rA;
        logic [3:0]        rB;
        logic [DATA_W-1:0] valC;
        logic [DATA_W-1:0] valP;
    } d_reg_t;

    localparam d_reg_t D_BUBBLE = '{stat: SAOK, icode: INOP, ifun: 4'h0,
                                    rA: NREG, rB: NREG, valC: '0, valP: '0};

endpackage

// File: rtl/decode_stage_regfile.sv
// rtl/decode_stage_regfile.sv - 15x64 program register file, two async read ports, two sync write ports
module decode_stage_regfile
    import decode_stage_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [3:0]        rd_a_addr_i,
    output logic [DATA_W-1:0] rd_a_data_o,
    input  logic [3:0]        rd_b_addr_i,
    output logic [DATA_W-1:0] rd_b_data_o,
    input  logic [3:0]        wr_e_addr_i,
    input  logic [DATA_W-1:0] wr_e_data_i,
    input  logic [3:0]        wr_m_addr_i,
    input  logic [DATA_W-1:0] wr_m_data_i
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // The M port wins a collision so popq %rsp leaves the popped value in %rsp.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!rst_n_i) begin
                regs_q[i] <= '0;
            end else if (wr_m_addr_i == 4'(i)) begin
                regs_q[i] <= wr_m_data_i;
            end else if (wr_e_addr_i == 4'(i)) begin
                regs_q[i] <= wr_e_data_i;
            end
        end
    end

    assign rd_a_data_o = (rd_a_addr_i == NREG) ? '0 : regs_q[rd_a_addr_i];
    assign rd_b_data_o = (rd_b_addr_i == NREG) ? '0 : regs_q[rd_b_addr_i];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - Y86-64 D stage: pipeline register, register file, operand select and forwarding
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              D_stall_i,
    input  logic              D_bubble_i,
    input  logic [3:0]        f_icode_i,
    input  logic [3:0]        f_ifun_i,
    input  logic [3:0]        f_rA_i,
    input  logic [3:0]        f_rB_i,
    input  logic [DATA_W-1:0] f_valC_i,
    input  logic [DATA_W-1:0] f_valP_i,
    input  logic [STAT_W-1:0] f_stat_i,
    input  logic [3:0]        e_dstE_i,
    input  logic [DATA_W-1:0] e_valE_i,
    input  logic [3:0]        M_dstM_i,
    input  logic [DATA_W-1:0] m_valM_i,
    input  logic [3:0]        M_dstE_i,
    input  logic [DATA_W-1:0] M_valE_i,
    input  logic [3:0]        W_dstM_i,
    input  logic [DATA_W-1:0] W_valM_i,
    input  logic [3:0]        W_dstE_i,
    input  logic [DATA_W-1:0] W_valE_i,
    output logic [STAT_W-1:0] d_stat_o,
    output logic [3:0]        d_icode_o,
    output logic [3:0]        d_ifun_o,
    output logic [DATA_W-1:0] d_valC_o,
    output logic [DATA_W-1:0] d_valA_o,
    output logic [DATA_W-1:0] d_valB_o,
    output logic [3:0]        d_dstE_o,
    output logic [3:0]        d_dstM_o,
    output logic [3:0]        d_srcA_o,
    output logic [3:0]        d_srcB_o
);

    d_reg_t            d_q, d_d;
    logic [3:0]        src_a, src_b, dst_e, dst_m;
    logic [DATA_W-1:0] rf_a, rf_b;

    always_comb begin
        d_d = d_q;
        if (!D_stall_i) begin
            d_d = D_bubble_i ? D_BUBBLE
                             : '{stat: f_stat_i, icode: f_icode_i, ifun: f_ifun_i,
                                 rA: f_rA_i, rB: f_rB_i, valC: f_valC_i, valP: f_valP_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            d_q <= D_BUBBLE;
        end else begin
            d_q <= d_d;
        end
    end

    always_comb begin
        src_a = NREG;
        src_b = NREG;
        dst_e = NREG;
        dst_m = NREG;
        case (d_q.icode)
            IRRMOVQ: begin src_a = d_q.rA; dst_e = d_q.rB; end
            IIRMOVQ: begin dst_e = d_q.rB; end
            IRMMOVQ: begin src_a = d_q.rA; src_b = d_q.rB; end
            IMRMOVQ: begin src_b = d_q.rB; dst_m = d_q.rA; end
            IOPQ:    begin src_a = d_q.rA; src_b = d_q.rB; dst_e = d_q.rB; end
            ICALL:   begin src_b = RSP; dst_e = RSP; end
            IRET:    begin src_a = RSP; src_b = RSP; dst_e = RSP; end
            IPUSHQ:  begin src_a = d_q.rA; src_b = RSP; dst_e = RSP; end
            IPOPQ:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = d_q.rA; end
            default: ;
        endcase
    end

    decode_stage_regfile u_regfile (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .rd_a_addr_i (src_a),
        .rd_a_data_o (rf_a),
        .rd_b_addr_i (src_b),
        .rd_b_data_o (rf_b),
        .wr_e_addr_i (W_dstE_i),
        .wr_e_data_i (W_valE_i),
        .wr_m_addr_i (W_dstM_i),
        .wr_m_data_i (W_valM_i)
    );

    // Youngest producer wins; NREG never matches so it falls through to the regfile's zero.
    function automatic logic [DATA_W-1:0] fwd(input logic [3:0] src, input logic [DATA_W-1:0] rf_val);
        if (src == NREG)          return '0;
        else if (src == e_dstE_i) return e_valE_i;
        else if (src == M_dstM_i) return m_valM_i;
        else if (src == M_dstE_i) return M_valE_i;
        else if (src == W_dstM_i) return W_valM_i;
        else if (src == W_dstE_i) return W_valE_i;
        else                      return rf_val;
    endfunction

    always_comb begin
        d_valA_o = fwd(src_a, rf_a);
        if (d_q.icode == ICALL || d_q.icode == IJXX) begin
            d_valA_o = d_q.valP;
        end
        d_valB_o = fwd(src_b, rf_b);
    end

    assign d_stat_o  = d_q.stat;
    assign d_icode_o = d_q.icode;
    assign d_ifun_o  = d_q.ifun;
    assign d_valC_o  = d_q.valC;
    assign d_dstE_o  = dst_e;
    assign d_dstM_o  = dst_m;
    assign d_srcA_o  = src_a;
    assign d_srcB_o  = src_b;

endmodule
